mac_seq_divider: RTL and testbench

//  Sequential restoring divider: 2W-bit dividend / W-bit divisor -> 2W-bit quotient + W-bit remainder.

---
 rtl/mac_pkg.sv | 12 +
 rtl/mac_div_step.sv | 26 ++
 rtl/mac_seq_divider.sv | 125 ++++++++++++
 tb/tb_mac_seq_divider.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and constants for the MAC datapath divider
package mac_pkg;

    localparam int MAC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mac_state_e;

endpackage

// File: rtl/mac_div_step.sv
// rtl/mac_div_step.sv - one combinational restoring-division step
module mac_div_step
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
) (
    input  logic [WIDTH:0]   prem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   prem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] trial;
    logic           ge;

    // Shift in the next dividend bit, subtract the divisor when it fits, otherwise restore
    always_comb begin
        trial   = {prem_i[WIDTH-1:0], bit_i};
        // a set top bit of prem would make the shifted value exceed any divisor
        ge      = prem_i[WIDTH] | (trial >= {1'b0, divisor_i});
        q_bit_o = ge;
        prem_o  = ge ? (trial - {1'b0, divisor_i}) : trial;
    end

endmodule

// File: rtl/mac_seq_divider.sv
// rtl/mac_seq_divider.sv - sequential 2W/W restoring divider with valid/ready handshakes
module mac_seq_divider
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int STEPS = 2 * WIDTH;
    localparam int CNT_W = $clog2(2 * WIDTH) + 1;

    mac_state_e           state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH:0]       prem_q, prem_d;
    logic [2*WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH:0]       step_prem_in;
    logic                 step_bit_in;
    logic [WIDTH-1:0]     step_dvsr_in;
    logic [WIDTH:0]       step_prem_out;
    logic                 step_q_bit;

    // The step unit performs the first iteration straight from the input operands
    // in the accepting cycle, so the result lands 2*WIDTH cycles after accept.
    always_comb begin
        step_prem_in = prem_q;
        step_bit_in  = quot_q[2*WIDTH-1];
        step_dvsr_in = dvsr_q;
        if (state_q == IDLE) begin
            step_prem_in = '0;
            step_bit_in  = dividend[2*WIDTH-1];
            step_dvsr_in = divisor;
        end
    end

    mac_div_step #(.WIDTH(WIDTH)) u_step (
        .prem_i    (step_prem_in),
        .bit_i     (step_bit_in),
        .divisor_i (step_dvsr_in),
        .prem_o    (step_prem_out),
        .q_bit_o   (step_q_bit)
    );

    // Next-state logic: accept in IDLE, iterate in BUSY, hold the result in DONE
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prem_d  = prem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        prem_d  = {1'b0, dividend[WIDTH-1:0]};
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        dvsr_d  = divisor;
                        prem_d  = step_prem_out;
                        quot_d  = {dividend[2*WIDTH-2:0], step_q_bit};
                        count_d = CNT_W'(1);
                        dbz_d   = 1'b0;
                    end
                end
            end
            BUSY: begin
                prem_d  = step_prem_out;
                quot_d  = {quot_q[2*WIDTH-2:0], step_q_bit};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            prem_q  <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prem_q  <= prem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = prem_q[WIDTH-1:0];
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mac_seq_divider.sv
// tb/tb_mac_seq_divider.sv - self-checking bench for mac_seq_divider
module tb_mac_seq_divider;

    localparam int W        = 8;
    localparam int N_RAND   = 2000;
    localparam int CYC_LIMIT = 95000;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2*W-1:0]  dividend;
    logic [W-1:0]    divisor;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  quotient;
    logic [W-1:0]    remainder;
    logic            div_by_zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mac_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        logic [2*W-1:0] exp_q;
        logic [W-1:0]   exp_r;
        logic           exp_dbz;
        int             exp_lat;
    } vec_t;

    vec_t vecs[6];

    typedef struct {
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
    } op_t;

    op_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Issue one op from IDLE, measure latency from the accept edge, take the result
    task automatic do_op(input logic [2*W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_take", {30'd0, out_valid, in_ready}, 32'h1);
    endtask

    // Reference: plain integer division, with the divide-by-zero convention
    function automatic void ref_div(input logic [2*W-1:0] a, input logic [W-1:0] b,
                                    output logic [2*W-1:0] q, output logic [W-1:0] r,
                                    output logic dbz);
        if (b == 0) begin
            q   = '1;
            r   = a[W-1:0];
            dbz = 1'b1;
        end else begin
            q   = a / {8'd0, b};
            r   = W'(a % {8'd0, b});
            dbz = 1'b0;
        end
    endfunction

    initial begin
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dbz;
        int             lat;
        int             n_done;

        vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 16};
        vecs[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 16};
        vecs[2] = '{16'd5,     8'd9,   16'd0,     8'd5,   1'b0, 16};
        vecs[3] = '{16'd100,   8'd0,   16'hFFFF,  8'h64,  1'b1, 1};
        vecs[4] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 16};
        vecs[5] = '{16'd0,     8'd200, 16'd0,     8'd0,   1'b0, 16};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", {31'd0, in_ready}, 32'h1);
        chk("reset_outputs", {7'd0, out_valid, quotient, remainder},
            32'h0);
        chk("reset_dbz", {31'd0, div_by_zero}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].dvd, vecs[i].dvs, q, r, dbz, lat);
            chk($sformatf("vec%0d_quotient", i), {16'd0, q}, {16'd0, vecs[i].exp_q});
            chk($sformatf("vec%0d_remainder", i), {24'd0, r}, {24'd0, vecs[i].exp_r});
            chk($sformatf("vec%0d_dbz", i), {31'd0, dbz}, {31'd0, vecs[i].exp_dbz});
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // Backpressure on a held result with stray in_valid pulses
        @(negedge clk);
        in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 16);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            chk("bp_hold", {7'd0, out_valid, quotient, remainder}, {7'd0, 1'b1, 16'd142, 8'd6});
            chk("bp_in_ready", {30'd0, in_ready, div_by_zero}, 32'h0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release", {30'd0, out_valid, in_ready}, 32'h1);
        do_op(16'd200, 8'd3, q, r, dbz, lat);
        chk("bp_next_op", {7'd0, dbz, q, r}, {7'd0, 1'b0, 16'd66, 8'd2});

        // Reset in the middle of a busy operation
        @(negedge clk);
        in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", {7'd0, out_valid, quotient, remainder}, 32'h0);
        chk("abort_flags", {30'd0, in_ready, div_by_zero}, 32'h2);
        do_op(16'd300, 8'd4, q, r, dbz, lat);
        chk("abort_next_op", {7'd0, dbz, q, r}, {7'd0, 1'b0, 16'd75, 8'd0});
        chk("abort_next_lat", lat, 16);

        // Random traffic with random handshakes against the reference model
        n_done = 0;
        fork
            begin : producer
                for (int i = 0; i < N_RAND && cyc < CYC_LIMIT; i++) begin
                    op_t op;
                    int  sel;
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    @(negedge clk);
                    op.dvd = 16'($urandom);
                    sel = $urandom_range(0, 15);
                    if (sel == 0)      op.dvs = 8'd0;
                    else if (sel < 4)  op.dvs = 8'($urandom_range(1, 3));
                    else               op.dvs = 8'($urandom);
                    in_valid = 1'b1;
                    dividend = op.dvd;
                    divisor  = op.dvs;
                    while (!in_ready && cyc < CYC_LIMIT) @(negedge clk);
                    sb.push_back(op);
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            begin : consumer
                while (n_done < N_RAND && cyc < CYC_LIMIT) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        op_t            op;
                        logic [2*W-1:0] eq;
                        logic [W-1:0]   er;
                        logic           ed;
                        if (sb.size() == 0) begin
                            chk("rand_unexpected_result", 32'd0, 32'd1);
                        end else begin
                            op = sb.pop_front();
                            ref_div(op.dvd, op.dvs, eq, er, ed);
                            chk("rand_result", {7'd0, div_by_zero, quotient, remainder},
                                {7'd0, ed, eq, er});
                            if (op.dvs != 0) begin
                                chk("rand_identity",
                                    {31'd0, (32'(quotient) * 32'(op.dvs) + 32'(remainder) == 32'(op.dvd))
                                            && (remainder < op.dvs)}, 32'd1);
                            end
                        end
                        n_done++;
                    end
                end
                out_ready = 1'b0;
            end
        join
        chk("rand_completed", n_done, N_RAND);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
